shared_mem_responder: RTL and testbench



---
 rtl/ui_pkg.sv | 28 ++
 rtl/sp_word_ram.sv | 39 +++
 rtl/shared_mem_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_shared_mem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared types and constants for the host/core memory responder.
//   addr_t    : word address as seen by both clients
//   word_t    : 32-bit data word
//   mem_op_e  : operation held in the core request path
//   mem_req_s : one core request (operation, address, write data)
package ui_pkg;

    localparam int UI_ADDR_W     = 21;
    localparam int START_BIT_POS = 16;

    typedef logic [UI_ADDR_W-1:0] addr_t;
    typedef logic [31:0]          word_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } mem_op_e;

    typedef struct packed {
        mem_op_e op;
        addr_t   addr;
        word_t   data;
    } mem_req_s;

    localparam mem_req_s REQ_IDLE = '{op: OP_NONE, addr: '0, data: '0};

endpackage

// File: rtl/sp_word_ram.sv
// Single-port word memory with a registered read port.
//   clk   : clock
//   en    : port enable for this cycle
//   we    : write when enabled, otherwise read
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after an enabled read; holds until
//           the next enabled read
// Contents are deliberately not reset so the array maps onto block RAM.
module sp_word_ram
    import ui_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [DEPTH];
    word_t rdata_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_reg <= mem[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/shared_mem_responder.sv
// Memory/flag responder shared between the PCI host and the FPGA core.
// One single-port word RAM is arbitrated every cycle: host access first,
// then a core request parked in the one-deep pending slot, then a fresh
// core request. A core request that loses to the host is parked and served
// on the next host-free cycle.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   pci_wr_en / pci_rd_en     : host write / read strobes
//   pci_req_addr              : host word address (FLAG_ADDR = flag register)
//   pci_input_data            : host write data
//   pci_rd_data, pci_rd_valid : host read result, one-cycle valid pulse
//   in_flag                   : command flags to the core (START bit pulses)
//   rd_req, FPGA_wr_en        : core read / write requests
//   req_addr, write_data      : core address / write data
//   rd_data, rd_ready         : core read result (held), one-cycle valid pulse
//   flag_we, out_flag         : core status register write
//   err                       : sticky error (out of range, dropped request)
module shared_mem_responder
    import ui_pkg::*;
#(
    parameter int              ADDR_W    = 21,
    parameter int              DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] FLAG_ADDR = {ADDR_W{1'b1}},
    parameter int              START_BIT = START_BIT_POS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pci_wr_en,
    input  logic              pci_rd_en,
    input  logic [ADDR_W-1:0] pci_req_addr,
    input  logic [31:0]       pci_input_data,
    output logic [31:0]       pci_rd_data,
    output logic              pci_rd_valid,
    output logic [31:0]       in_flag,
    input  logic              rd_req,
    input  logic              FPGA_wr_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       rd_data,
    output logic              rd_ready,
    input  logic              flag_we,
    input  logic [31:0]       out_flag,
    output logic              err
);

    localparam int                RAM_AW  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    // RAM port
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    word_t             ram_wdata;
    word_t             ram_rdata;

    // State
    mem_req_s pend_reg, pend_next;
    word_t    in_flag_reg, in_flag_next;
    word_t    status_reg, status_next;
    logic     err_reg, err_next;

    // Read-return bookkeeping: which client the RAM output belongs to next
    // cycle, and whether the answer is forced rather than taken from the RAM.
    logic     core_done_reg, core_done_next;
    logic     core_zero_reg, core_zero_next;
    logic     pci_done_reg, pci_done_next;
    logic     pci_flag_reg, pci_flag_next;
    logic     pci_zero_reg, pci_zero_next;
    word_t    pci_flag_data_reg, pci_flag_data_next;
    word_t    rd_data_hold_reg;
    word_t    pci_hold_reg;

    // Arbitration helpers
    logic     host_act;
    mem_op_e  new_op;
    mem_req_s new_req;
    mem_req_s core_serve;

    sp_word_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        pend_next          = pend_reg;
        in_flag_next       = in_flag_reg;
        in_flag_next[START_BIT] = 1'b0;            // start bit is a pulse
        status_next        = flag_we ? out_flag : status_reg;
        err_next           = err_reg;
        pci_flag_data_next = pci_flag_data_reg;

        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;

        core_done_next = 1'b0;
        core_zero_next = 1'b0;
        pci_done_next  = 1'b0;
        pci_flag_next  = 1'b0;
        pci_zero_next  = 1'b0;

        host_act = pci_wr_en | pci_rd_en;

        // A simultaneous core read and write keeps the write only.
        new_op = OP_NONE;
        if (FPGA_wr_en) begin
            new_op = OP_WR;
            if (rd_req) begin
                err_next = 1'b1;
            end
        end else if (rd_req) begin
            new_op = OP_RD;
        end
        new_req = '{op: new_op, addr: addr_t'(req_addr), data: write_data};

        core_serve = REQ_IDLE;

        if (host_act) begin
            // Host owns the port; park the core request or drop it if the
            // slot is already taken.
            if (new_op != OP_NONE) begin
                if (pend_reg.op != OP_NONE) begin
                    err_next = 1'b1;
                end else begin
                    pend_next = new_req;
                end
            end

            if (pci_wr_en) begin
                if (pci_req_addr == FLAG_ADDR) begin
                    in_flag_next = pci_input_data;
                end else if (pci_req_addr < DEPTH_A) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = pci_req_addr[RAM_AW-1:0];
                    ram_wdata = pci_input_data;
                end else begin
                    err_next = 1'b1;
                end
            end else begin
                pci_done_next = 1'b1;
                if (pci_req_addr == FLAG_ADDR) begin
                    // Sampled before this edge's flag_we takes effect.
                    pci_flag_next      = 1'b1;
                    pci_flag_data_next = status_reg;
                end else if (pci_req_addr < DEPTH_A) begin
                    ram_en   = 1'b1;
                    ram_addr = pci_req_addr[RAM_AW-1:0];
                end else begin
                    pci_zero_next = 1'b1;
                    err_next      = 1'b1;
                end
            end
        end else if (pend_reg.op != OP_NONE) begin
            // The slot drains this cycle, so a new request can take its place.
            core_serve = pend_reg;
            pend_next  = new_req;
        end else begin
            core_serve = new_req;
        end

        // FLAG_ADDR lies above DEPTH, so the range test also rejects it here.
        if (core_serve.op == OP_RD) begin
            core_done_next = 1'b1;
            if (core_serve.addr < DEPTH_A) begin
                ram_en   = 1'b1;
                ram_addr = core_serve.addr[RAM_AW-1:0];
            end else begin
                core_zero_next = 1'b1;
                err_next       = 1'b1;
            end
        end else if (core_serve.op == OP_WR) begin
            if (core_serve.addr < DEPTH_A) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = core_serve.addr[RAM_AW-1:0];
                ram_wdata = core_serve.data;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg          <= REQ_IDLE;
            in_flag_reg       <= '0;
            status_reg        <= '0;
            err_reg           <= 1'b0;
            core_done_reg     <= 1'b0;
            core_zero_reg     <= 1'b0;
            pci_done_reg      <= 1'b0;
            pci_flag_reg      <= 1'b0;
            pci_zero_reg      <= 1'b0;
            pci_flag_data_reg <= '0;
            rd_data_hold_reg  <= '0;
            pci_hold_reg      <= '0;
        end else begin
            pend_reg          <= pend_next;
            in_flag_reg       <= in_flag_next;
            status_reg        <= status_next;
            err_reg           <= err_next;
            core_done_reg     <= core_done_next;
            core_zero_reg     <= core_zero_next;
            pci_done_reg      <= pci_done_next;
            pci_flag_reg      <= pci_flag_next;
            pci_zero_reg      <= pci_zero_next;
            pci_flag_data_reg <= pci_flag_data_next;
            rd_data_hold_reg  <= rd_data;
            pci_hold_reg      <= pci_rd_data;
        end
    end

    // Read results come straight off the RAM register in the valid cycle and
    // are then held locally, since the RAM output moves with the other client.
    assign rd_ready     = core_done_reg;
    assign rd_data      = core_done_reg ? (core_zero_reg ? '0 : ram_rdata)
                                        : rd_data_hold_reg;
    assign pci_rd_valid = pci_done_reg;
    assign pci_rd_data  = pci_done_reg ? (pci_flag_reg ? pci_flag_data_reg :
                                          pci_zero_reg ? '0 : ram_rdata)
                                       : pci_hold_reg;
    assign in_flag      = in_flag_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_shared_mem_responder.sv
module tb_shared_mem_responder;

    localparam logic [20:0] FA = 21'h1FFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        pci_wr_en, pci_rd_en;
    logic [20:0] pci_req_addr;
    logic [31:0] pci_input_data;
    logic [31:0] pci_rd_data;
    logic        pci_rd_valid;
    logic [31:0] in_flag;
    logic        rd_req, FPGA_wr_en;
    logic [20:0] req_addr;
    logic [31:0] write_data;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic        flag_we;
    logic [31:0] out_flag;
    logic        err;

    shared_mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .pci_wr_en      (pci_wr_en),
        .pci_rd_en      (pci_rd_en),
        .pci_req_addr   (pci_req_addr),
        .pci_input_data (pci_input_data),
        .pci_rd_data    (pci_rd_data),
        .pci_rd_valid   (pci_rd_valid),
        .in_flag        (in_flag),
        .rd_req         (rd_req),
        .FPGA_wr_en     (FPGA_wr_en),
        .req_addr       (req_addr),
        .write_data     (write_data),
        .rd_data        (rd_data),
        .rd_ready       (rd_ready),
        .flag_we        (flag_we),
        .out_flag       (out_flag),
        .err            (err)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus what is expected from it.
    // rd_lat: cycles until rd_ready for a core read (0 = no read expected).
    // exp_flag / exp_err: in_flag / err one cycle after the vector.
    typedef struct {
        logic        pw;
        logic        pr;
        logic [20:0] pa;
        logic [31:0] pd;
        logic        rq;
        logic        cw;
        logic [20:0] ca;
        logic [31:0] cd;
        logic        fw;
        logic [31:0] of;
        logic [31:0] exp_rd;
        int          rd_lat;
        logic [31:0] exp_prd;
        logic [31:0] exp_flag;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t core_q[$];
    exp_t pci_q[$];
    vec_t tbl[23];
    vec_t v;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int vid   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: pops an expectation whenever a valid pulse shows up and
    // flags both unexpected pulses and expectations that went overdue.
    task automatic monitor();
        exp_t e;
        if (rd_ready === 1'b1) begin
            if (core_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL core_rd_unexpected: got rd_ready=1 data %h, expected no pulse (cycle %0d)", rd_data, cyc);
            end else begin
                e = core_q.pop_front();
                chk("core_rd_data", rd_data, e.d);
                chk("core_rd_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (core_q.size() > 0 && core_q[0].due <= cyc) begin
            e = core_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL core_rd_missing: got no rd_ready, expected data %h by cycle %0d", e.d, e.due);
        end
        if (pci_rd_valid === 1'b1) begin
            if (pci_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL pci_rd_unexpected: got pci_rd_valid=1 data %h, expected no pulse (cycle %0d)", pci_rd_data, cyc);
            end else begin
                e = pci_q.pop_front();
                chk("pci_rd_data", pci_rd_data, e.d);
                chk("pci_rd_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (pci_q.size() > 0 && pci_q[0].due <= cyc) begin
            e = pci_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL pci_rd_missing: got no pci_rd_valid, expected data %h by cycle %0d", e.d, e.due);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic apply(input vec_t s);
        pci_wr_en      = s.pw;
        pci_rd_en      = s.pr;
        pci_req_addr   = s.pa;
        pci_input_data = s.pd;
        rd_req         = s.rq;
        FPGA_wr_en     = s.cw;
        req_addr       = s.ca;
        write_data     = s.cd;
        flag_we        = s.fw;
        out_flag       = s.of;
    endtask

    task automatic run_vec(input vec_t s);
        exp_t e;
        apply(s);
        if (s.rd_lat > 0) begin
            e.d   = s.exp_rd;
            e.due = cyc + s.rd_lat;
            core_q.push_back(e);
        end
        if (s.pr && !s.pw) begin
            e.d   = s.exp_prd;
            e.due = cyc + 1;
            pci_q.push_back(e);
        end
        tick();
        chk("err", {31'd0, err}, {31'd0, s.exp_err});
        chk("in_flag", in_flag, s.exp_flag);
        $display("vec %0d: pw=%0b pr=%0b pa=%h pd=%h rq=%0b cw=%0b ca=%h cd=%h fw=%0b -> err=%0b in_flag=%h",
                 vid, s.pw, s.pr, s.pa, s.pd, s.rq, s.cw, s.ca, s.cd, s.fw, err, in_flag);
        vid++;
    endtask

    function automatic vec_t idle_v(input logic [31:0] f, input logic e);
        vec_t r;
        r = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, f, e};
        return r;
    endfunction

    task automatic do_reset();
        apply(idle_v(0, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pci_rd_data"},  pci_rd_data, 32'h0);
        chk({tag, "_pci_rd_valid"}, {31'd0, pci_rd_valid}, 32'h0);
        chk({tag, "_rd_data"},      rd_data, 32'h0);
        chk({tag, "_rd_ready"},     {31'd0, rd_ready}, 32'h0);
        chk({tag, "_in_flag"},      in_flag, 32'h0);
        chk({tag, "_err"},          {31'd0, err}, 32'h0);
    endtask

    initial begin
        //          pw pr pa          pd            rq cw ca          cd            fw of  exp_rd        lat exp_prd       flag          err
        tbl[0]  = '{1, 0, 21'd5,     32'h41434143, 0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0};
        tbl[1]  = '{1, 0, 21'd7,     32'h11111111, 0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0};
        tbl[2]  = '{0, 0, 21'd0,     32'h0,        1, 0, 21'd5,    32'h0,        0, 0, 32'h41434143, 1, 32'h0,        32'h0,        0};
        tbl[3]  = idle_v(32'h0, 0);
        tbl[4]  = '{1, 0, 21'd7,     32'hDEADBEEF, 1, 0, 21'd7,    32'h0,        0, 0, 32'hDEADBEEF, 2, 32'h0,        32'h0,        0};
        tbl[5]  = idle_v(32'h0, 0);
        tbl[6]  = '{1, 0, FA,        32'h00010000, 0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h00010000, 0};
        tbl[7]  = idle_v(32'h0, 0);
        tbl[8]  = '{1, 0, FA,        32'h00000003, 0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h3,        0};
        tbl[9]  = idle_v(32'h3, 0);
        tbl[10] = '{0, 0, 21'd0,     32'h0,        0, 0, 21'd0,    32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h3,        0};
        tbl[11] = '{0, 1, FA,        32'h0,        0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h1,        32'h3,        0};
        tbl[12] = '{0, 1, FA,        32'h0,        0, 0, 21'd0,    32'h0,        1, 2, 32'h0,        0, 32'h1,        32'h3,        0};
        tbl[13] = '{0, 1, FA,        32'h0,        0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h2,        32'h3,        0};
        tbl[14] = '{0, 0, 21'd0,     32'h0,        0, 1, 21'd9,    32'hCAFEF00D, 0, 0, 32'h0,        0, 32'h0,        32'h3,        0};
        tbl[15] = '{0, 0, 21'd0,     32'h0,        1, 0, 21'd9,    32'h0,        0, 0, 32'hCAFEF00D, 1, 32'h0,        32'h3,        0};
        tbl[16] = '{0, 1, 21'd9,     32'h0,        0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'hCAFEF00D, 32'h3,        0};
        tbl[17] = '{1, 1, 21'd10,    32'h12345678, 0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h3,        0};
        tbl[18] = '{0, 1, 21'd10,    32'h0,        0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h12345678, 32'h3,        0};
        tbl[19] = '{1, 0, 21'd4095,  32'h0BADC0DE, 0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h3,        0};
        tbl[20] = '{0, 0, 21'd0,     32'h0,        1, 0, 21'd4095, 32'h0,        0, 0, 32'h0BADC0DE, 1, 32'h0,        32'h3,        0};
        tbl[21] = '{0, 0, 21'd0,     32'h0,        1, 0, 21'd4096, 32'h0,        0, 0, 32'h0,        1, 32'h0,        32'h3,        1};
        tbl[22] = '{0, 1, 21'd4095,  32'h0,        0, 0, 21'd0,    32'h0,        0, 0, 32'h0,        0, 32'h0BADC0DE, 32'h3,        1};

        apply(idle_v(0, 0));
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_all_zero("reset");

        for (int i = 0; i < 23; i++) begin
            run_vec(tbl[i]);
        end

        // Second request while the first is stalled behind three host writes.
        do_reset();
        v = '{1, 0, 21'd20, 32'h1, 1, 0, 21'd5, 32'h0, 0, 0, 32'h41434143, 4, 32'h0, 32'h0, 0};
        run_vec(v);
        v = '{1, 0, 21'd21, 32'h2, 1, 0, 21'd7, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1};
        run_vec(v);
        v = '{1, 0, 21'd22, 32'h3, 0, 0, 21'd0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1};
        run_vec(v);
        run_vec(idle_v(0, 1));
        run_vec(idle_v(0, 1));

        // Core read and write together: write lands, read is dropped.
        do_reset();
        v = '{0, 0, 21'd0, 32'h0, 1, 1, 21'd11, 32'hABCD0123, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1};
        run_vec(v);
        v = '{0, 0, 21'd0, 32'h0, 1, 0, 21'd11, 32'h0, 0, 0, 32'hABCD0123, 1, 32'h0, 32'h0, 1};
        run_vec(v);
        run_vec(idle_v(0, 1));
        run_vec(idle_v(0, 1));
        chk("rd_data_hold", rd_data, 32'hABCD0123);

        // Reset the cycle after a stalled read: it must never complete.
        do_reset();
        v = '{1, 0, FA, 32'h3, 0, 0, 21'd0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h3, 0};
        run_vec(v);
        v = '{1, 0, 21'd30, 32'h55, 1, 0, 21'd5, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h3, 0};
        run_vec(v);
        do_reset();
        run_vec(idle_v(0, 0));
        run_vec(idle_v(0, 0));
        chk_all_zero("midop_reset");
        v = '{0, 0, 21'd0, 32'h0, 1, 0, 21'd5, 32'h0, 0, 0, 32'h41434143, 1, 32'h0, 32'h0, 0};
        run_vec(v);

        apply(idle_v(0, 0));
        repeat (4) tick();
        chk("core_queue_drained", 32'(core_q.size()), 32'h0);
        chk("pci_queue_drained", 32'(pci_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
